dmem_access_unit: RTL and testbench
===================================

Name: dmem_access_unit

Overview:
- Load/store sequencer directly upstream of the data memory, between the MEM pipeline stage and the DMem port.
- The data memory only performs accesses contained in one aligned word: bytes at any offset, halves at offset 0/2, words at offset 0.
- This block accepts arbitrary RV32 load/store requests, passes aligned ones through in one cycle, and splits misaligned ones into multi-cycle sequences. It returns load data with a valid pulse and stalls the pipeline while busy.

Parameters:
- ADDR_W, 32, address width; wrap-around is modulo 2^ADDR_W.
- SPLIT_EN, 1: 1 = misaligned accesses are split; 0 = the low address bits required for alignment are cleared and the access completes as aligned in one cycle.

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32 funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- busy  out  1  state != IDLE (pipeline stall)
- mem_re  out  1  DMem readEnable
- mem_we  out  1  DMem writeEnable
- mem_addr  out  ADDR_W  DMem addr
- mem_size  out  3  DMem unitSize (funct3 encoding)
- mem_wdata  out  32  DMem writeData
- mem_rdata  in  32  DMem readData (combinational)

Behaviour:
- Clock and reset: one clock, clk; reset rstn is synchronous and active-low.
- Reset values: state IDLE; resp_valid 0; resp_rdata 0; latched request and lo-word registers 0.
- While rstn == 0: req_ready, mem_re and mem_we are forced to 0 combinationally.
- Reset mid-sequence: the sequence is abandoned with no resp_valid. Bytes already written stay written.
- Size decode: req_funct3[1:0] gives 00 byte, 01 half, 10 or 11 word. Bit 2 selects zero-extension for loads only. Stores send mem_size 000/001/010.
- Misaligned when: half && addr[0]; or word && addr[1:0] != 0. Bytes are never misaligned.
- req_ready = (state == IDLE) && rstn. Request fields are latched on accept; upstream may change them afterwards.
- Aligned access (acceptance cycle):
  - mem_* driven combinationally from req_* in the acceptance cycle.
  - Load: mem_rdata is registered into resp_rdata at the edge.
  - Store: the write commits at the same edge.
  - resp_valid = 1 in the next cycle. Latency 1; state stays IDLE.
- Misaligned load (latency 2):
  - Accept cycle: mem_re, mem_size = 010, mem_addr = addr & ~3. lo <= mem_rdata. Go to LD_HI.
  - LD_HI: mem_re, mem_size = 010, mem_addr = (addr & ~3) + 4 (wraps).
  - Result = ({mem_rdata, lo} >> 8*addr[1:0]), truncated to 16 or 32 bits, then sign- or zero-extended into resp_rdata. Go to IDLE.
  - resp_valid = 1 the following cycle.
- Misaligned store (latency n, n = 2 for half, 4 for word):
  - Step k = 0..n-1: mem_we, mem_size = 000, mem_addr = addr + k (wraps), mem_wdata = {24'b0, wdata[8k+7:8k]}.
  - Step 0 is the accept cycle; steps 1..n-1 run in state ST_BYTE with a 2-bit counter. Return to IDLE after step n-1.
  - resp_valid the next cycle, with resp_rdata = 0.
- Outside active steps, mem_re = mem_we = 0; mem_addr, mem_size and mem_wdata are don't-care.
- Back-to-back: resp_valid and req_ready may both be 1 in the same cycle. A new request is accepted then, giving zero bubble cycles between aligned accesses.
- resp_valid is never held; downstream cannot stall it.

Test Plan:
- Memory preset for all cases: word 0x100 = 0x44332211, word 0x104 = 0x88776655.
- LW 0x100 -> one cycle mem_re at 0x100, size 010; next cycle resp_valid = 1, resp_rdata = 0x44332211, busy never 1.
- LW 0x102 -> mem_re at 0x100 then 0x104, busy 1 for one cycle; resp_rdata = 0x66554433 two cycles after accept. LHU 0x101 -> split path, 0x00003322. LB 0x107 -> aligned, 0xFFFFFF88.
- SW 0x0FE, data 0xAABBCCDD:
  - Byte writes at 0xFE/0xFF/0x100/0x101 with data DD/CC/BB/AA over 4 cycles; req_ready 0 for 3 cycles.
  - resp_valid in cycle 4; afterwards word 0x100 = 0x4433AABB.
- Same SW, rstn low for one cycle after the 2nd byte -> no resp_valid, only 0xFE and 0xFF written, word 0x100 unchanged; req_ready = 1 the cycle after rstn returns high.
- Back-to-back aligned SW 0x104 = 0x12345678 then LW 0x104 -> accepted on consecutive cycles, LW returns 0x12345678.
- LW 0xFFFFFFFE -> second access at 0x00000000.
- SPLIT_EN = 0, LW 0x102 -> single access at 0x100, resp 0x44332211.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// dmem_access_unit_if: request/response and data-memory port bundle for the load/store sequencer
interface dmem_access_unit_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              busy;
  logic              mem_re;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [2:0]        mem_size;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, busy, mem_re, mem_we, mem_addr, mem_size, mem_wdata
  );
  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, busy, mem_re, mem_we, mem_addr, mem_size, mem_wdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: sequences RV32 loads/stores onto a word-contained data memory, splitting misaligned ones
module dmem_access_unit #(
  parameter int ADDR_W   = 32,
  parameter bit SPLIT_EN = 1'b1
) (
  input logic clk,
  input logic rstn,
  dmem_access_unit_if.slave bus
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] LD_HI   = 2'd1;
  localparam logic [1:0] ST_BYTE = 2'd2;
  logic [1:0]        state, cnt;
  logic [ADDR_W-1:0] l_addr, hi_addr, a_addr;
  logic [2:0]        l_f3;
  logic [31:0]       l_wdata, lo, sh;
  logic              is_half, is_word, mis, acc;
  function automatic logic [31:0] ext(input logic [31:0] d, input logic [2:0] f);
    return f[1] ? d : f[0] ? {{16{~f[2] & d[15]}}, d[15:0]} : {{24{~f[2] & d[7]}}, d[7:0]};
  endfunction
  always_comb begin
    is_half = bus.req_funct3[1:0] == 2'b01;
    is_word = bus.req_funct3[1];
    mis     = SPLIT_EN && ((is_half && bus.req_addr[0]) || (is_word && bus.req_addr[1:0] != 2'b00));
    acc     = bus.req_valid && bus.req_ready;
    // without splitting, the offending low bits are dropped so the access lands aligned
    a_addr  = SPLIT_EN ? bus.req_addr
            : {bus.req_addr[ADDR_W-1:2], is_word ? 2'b00 : {bus.req_addr[1], bus.req_addr[0] & ~is_half}};
    hi_addr = {l_addr[ADDR_W-1:2], 2'b00} + ADDR_W'(4);
    sh      = 32'({bus.mem_rdata, lo} >> {l_addr[1:0], 3'b000});
  end
  assign bus.req_ready = state == IDLE && rstn;
  assign bus.busy      = state != IDLE;
  always_comb begin
    bus.mem_re    = rstn && (state == LD_HI || (acc && !bus.req_write));
    bus.mem_we    = rstn && (state == ST_BYTE || (acc && bus.req_write));
    bus.mem_addr  = state == LD_HI ? hi_addr
                  : state == ST_BYTE ? l_addr + ADDR_W'(cnt)
                  : mis && !bus.req_write ? {bus.req_addr[ADDR_W-1:2], 2'b00} : a_addr;
    bus.mem_size  = state == LD_HI ? 3'b010 : state == ST_BYTE ? 3'b000
                  : mis ? (bus.req_write ? 3'b000 : 3'b010) : {1'b0, is_word ? 2'b10 : bus.req_funct3[1:0]};
    bus.mem_wdata = state == ST_BYTE ? {24'b0, 8'(l_wdata >> {cnt, 3'b000})}
                  : mis ? {24'b0, bus.req_wdata[7:0]} : bus.req_wdata;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state          <= IDLE;
      cnt            <= 2'd0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      l_addr         <= '0;
      l_f3           <= '0;
      l_wdata        <= '0;
      lo             <= '0;
    end else begin
      bus.resp_valid <= 1'b0;
      if (acc) begin
        l_addr         <= bus.req_addr;
        l_f3           <= bus.req_funct3;
        l_wdata        <= bus.req_wdata;
        lo             <= bus.mem_rdata;
        cnt            <= 2'd1;
        state          <= mis ? (bus.req_write ? ST_BYTE : LD_HI) : IDLE;
        bus.resp_valid <= !mis;
        if (!mis) bus.resp_rdata <= bus.req_write ? '0 : ext(bus.mem_rdata, bus.req_funct3);
      end else if (state == LD_HI) begin
        state          <= IDLE;
        bus.resp_valid <= 1'b1;
        bus.resp_rdata <= ext(sh, l_f3);
      end else if (state == ST_BYTE) begin
        cnt <= cnt + 2'd1;
        if (cnt == (l_f3[1] ? 2'd3 : 2'd1)) begin
          state          <= IDLE;
          bus.resp_valid <= 1'b1;
          bus.resp_rdata <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: scoreboard bench with a byte-array data memory behind split and non-split instances
module tb_dmem_access_unit;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;
  dmem_access_unit_if #(.ADDR_W(32)) b0 ();
  dmem_access_unit_if #(.ADDR_W(32)) b1 ();
  dmem_access_unit #(.ADDR_W(32), .SPLIT_EN(1'b1)) u0 (.clk(clk), .rstn(rstn), .bus(b0));
  dmem_access_unit #(.ADDR_W(32), .SPLIT_EN(1'b0)) u1 (.clk(clk), .rstn(rstn), .bus(b1));
  logic [7:0]  mem [0:511];
  logic [31:0] w0, w1;
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    for (int k = 0; k < (s[1] ? 4 : s[0] ? 2 : 1); k++)
      mem[a[8:0] + 9'(k)] = 8'(d >> (8 * k));
  endtask
  function automatic logic [31:0] word(input logic [8:0] a);
    return {mem[a + 9'd3], mem[a + 9'd2], mem[a + 9'd1], mem[a]};
  endfunction
  task automatic preset();
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    wr(32'h100, 3'b010, 32'h44332211);
    wr(32'h104, 3'b010, 32'h88776655);
    wr(32'h1FC, 3'b010, 32'hA55A0000);
    wr(32'h000, 3'b010, 32'h04030201);
  endtask
  // memory returns the addressed unit right-aligned
  always_comb begin
    w0 = {mem[b0.mem_addr[8:0] + 9'd3], mem[b0.mem_addr[8:0] + 9'd2], mem[b0.mem_addr[8:0] + 9'd1], mem[b0.mem_addr[8:0]]};
    w1 = {mem[b1.mem_addr[8:0] + 9'd3], mem[b1.mem_addr[8:0] + 9'd2], mem[b1.mem_addr[8:0] + 9'd1], mem[b1.mem_addr[8:0]]};
    b0.mem_rdata = !b0.mem_re ? 32'h0 : b0.mem_size[1] ? w0 : b0.mem_size[0] ? {16'h0, w0[15:0]} : {24'h0, w0[7:0]};
    b1.mem_rdata = !b1.mem_re ? 32'h0 : b1.mem_size[1] ? w1 : b1.mem_size[0] ? {16'h0, w1[15:0]} : {24'h0, w1[7:0]};
  end
  always @(posedge clk) begin
    if (b0.mem_we) wr(b0.mem_addr, b0.mem_size, b0.mem_wdata);
    if (b1.mem_we) wr(b1.mem_addr, b1.mem_size, b1.mem_wdata);
  end
  always @(negedge clk) begin
    if (b0.resp_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexp_resp got %h exp none", b0.resp_rdata);
      end else chk("resp", b0.resp_rdata, exp_q.pop_front());
    end
  end
  task automatic req(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    b0.req_valid  = 1'b1;
    b0.req_write  = w;
    b0.req_funct3 = f3;
    b0.req_addr   = a;
    b0.req_wdata  = d;
  endtask
  task automatic xact(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp, input int lat);
    int c;
    @(negedge clk);
    req(w, f3, a, d);
    c = 0;
    while (!b0.req_ready && c < 10) begin
      @(negedge clk);
      c++;
    end
    exp_q.push_back(exp);
    @(negedge clk);
    b0.req_valid = 1'b0;
    c = 1;
    while (!b0.resp_valid && c < 10) begin
      @(negedge clk);
      c++;
    end
    chk("latency", 32'(c), 32'(lat));
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  initial begin
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_funct3 = 3'b0; b0.req_addr = '0; b0.req_wdata = '0;
    b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_funct3 = 3'b0; b1.req_addr = '0; b1.req_wdata = '0;
    preset();
    repeat (2) @(negedge clk);
    req(1'b0, 3'b010, 32'h100, 32'h0);
    #1;
    chk("rst_ready", 32'(b0.req_ready), 32'd0);
    chk("rst_re", 32'(b0.mem_re), 32'd0);
    chk("rst_valid", 32'(b0.resp_valid), 32'd0);
    chk("rst_rdata", b0.resp_rdata, 32'h0);
    chk("rst_busy", 32'(b0.busy), 32'd0);
    b0.req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("ready_after_rst", 32'(b0.req_ready), 32'd1);
    @(negedge clk);
    req(1'b0, 3'b010, 32'h100, 32'h0);
    exp_q.push_back(32'h44332211);
    #1;
    chk("lw_re", 32'(b0.mem_re), 32'd1);
    chk("lw_addr", b0.mem_addr, 32'h100);
    chk("lw_size", 32'(b0.mem_size), 32'd2);
    chk("lw_busy", 32'(b0.busy), 32'd0);
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("lw_valid", 32'(b0.resp_valid), 32'd1);
    chk("lw_busy2", 32'(b0.busy), 32'd0);
    @(negedge clk);
    req(1'b0, 3'b010, 32'h102, 32'h0);
    exp_q.push_back(32'h66554433);
    #1;
    chk("lwm_addr0", b0.mem_addr, 32'h100);
    chk("lwm_re0", 32'(b0.mem_re), 32'd1);
    chk("lwm_size0", 32'(b0.mem_size), 32'd2);
    @(negedge clk);
    b0.req_valid = 1'b0;
    #1;
    chk("lwm_busy", 32'(b0.busy), 32'd1);
    chk("lwm_ready", 32'(b0.req_ready), 32'd0);
    chk("lwm_re1", 32'(b0.mem_re), 32'd1);
    chk("lwm_addr1", b0.mem_addr, 32'h104);
    chk("lwm_valid_early", 32'(b0.resp_valid), 32'd0);
    @(negedge clk);
    chk("lwm_valid", 32'(b0.resp_valid), 32'd1);
    chk("lwm_busy_end", 32'(b0.busy), 32'd0);
    xact(1'b0, 3'b101, 32'h101, 32'h0, 32'h00003322, 2);
    xact(1'b0, 3'b000, 32'h107, 32'h0, 32'hFFFFFF88, 1);
    xact(1'b0, 3'b010, 32'h101, 32'h0, 32'h55443322, 2);
    xact(1'b0, 3'b001, 32'h106, 32'h0, 32'hFFFF8877, 1);
    xact(1'b0, 3'b101, 32'h106, 32'h0, 32'h00008877, 1);
    @(negedge clk);
    req(1'b1, 3'b010, 32'h0FE, 32'hAABBCCDD);
    exp_q.push_back(32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("sw_we", 32'(b0.mem_we), 32'd1);
      chk("sw_addr", b0.mem_addr, 32'h0FE + 32'(k));
      chk("sw_size", 32'(b0.mem_size), 32'd0);
      chk("sw_wdata", b0.mem_wdata, 32'(8'(32'hAABBCCDD >> (8 * k))));
      chk("sw_ready", 32'(b0.req_ready), 32'(k == 0));
      @(negedge clk);
      b0.req_valid = 1'b0;
    end
    chk("sw_valid", 32'(b0.resp_valid), 32'd1);
    chk("sw_mem", word(9'h100), 32'h4433AABB);
    preset();
    @(negedge clk);
    req(1'b1, 3'b010, 32'h0FE, 32'hAABBCCDD);
    @(negedge clk);
    b0.req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rmid_we", 32'(b0.mem_we), 32'd0);
    chk("rmid_ready", 32'(b0.req_ready), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rmid_ready_back", 32'(b0.req_ready), 32'd1);
    chk("rmid_valid", 32'(b0.resp_valid), 32'd0);
    chk("rmid_busy", 32'(b0.busy), 32'd0);
    repeat (3) @(negedge clk);
    chk("rmid_fe", 32'(mem[9'h0FE]), 32'hDD);
    chk("rmid_ff", 32'(mem[9'h0FF]), 32'hCC);
    chk("rmid_word", word(9'h100), 32'h44332211);
    req(1'b1, 3'b010, 32'h104, 32'h12345678);
    exp_q.push_back(32'h0);
    #1 chk("b2b_ready0", 32'(b0.req_ready), 32'd1);
    @(negedge clk);
    req(1'b0, 3'b010, 32'h104, 32'h0);
    exp_q.push_back(32'h12345678);
    #1;
    chk("b2b_ready1", 32'(b0.req_ready), 32'd1);
    chk("b2b_valid1", 32'(b0.resp_valid), 32'd1);
    chk("b2b_re", 32'(b0.mem_re), 32'd1);
    @(negedge clk);
    b0.req_valid = 1'b0;
    chk("b2b_valid2", 32'(b0.resp_valid), 32'd1);
    preset();
    @(negedge clk);
    req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0);
    exp_q.push_back(32'h0201A55A);
    #1 chk("wrap_addr0", b0.mem_addr, 32'hFFFFFFFC);
    @(negedge clk);
    b0.req_valid = 1'b0;
    #1 chk("wrap_addr1", b0.mem_addr, 32'h00000000);
    @(negedge clk);
    chk("wrap_valid", 32'(b0.resp_valid), 32'd1);
    xact(1'b1, 3'b001, 32'h101, 32'h0000BEEF, 32'h0, 2);
    chk("sh_mem", word(9'h100), 32'h44BEEF11);
    xact(1'b0, 3'b001, 32'h101, 32'h0, 32'hFFFFBEEF, 2);
    preset();
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_write = 1'b0; b1.req_funct3 = 3'b010; b1.req_addr = 32'h102;
    #1;
    chk("ns_addr", b1.mem_addr, 32'h100);
    chk("ns_size", 32'(b1.mem_size), 32'd2);
    chk("ns_re", 32'(b1.mem_re), 32'd1);
    @(negedge clk);
    b1.req_valid = 1'b0;
    chk("ns_valid", 32'(b1.resp_valid), 32'd1);
    chk("ns_rdata", b1.resp_rdata, 32'h44332211);
    chk("ns_busy", 32'(b1.busy), 32'd0);
    repeat (2) @(negedge clk);
    chk("q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
